// File: rtl/periplex_pkg.sv
// ============================================================================
// periplex_pkg
// ----------------------------------------------------------------------------
// Definitions shared by the UART transmit path and the APB slave that feeds
// it.  Both sides agree on the FSM state encoding (so the slave can mirror or
// decode it) and on the meaning of the 2-bit byte-count code.
//
// Contents:
//   uart_state_t   - transmitter FSM states, fixed binary encoding
//   NBYTES_*       - byte-count codes carried on nbytes (value + 1 = bytes)
// ============================================================================
package periplex_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_t;

    localparam logic [1:0] NBYTES_1 = 2'b00;
    localparam logic [1:0] NBYTES_2 = 2'b01;
    localparam logic [1:0] NBYTES_3 = 2'b10;
    localparam logic [1:0] NBYTES_4 = 2'b11;

endpackage

// File: rtl/uart_baud_tick.sv
// ============================================================================
// uart_baud_tick
// ----------------------------------------------------------------------------
// Bit-period timer for the UART transmitter.  While run is high the counter
// steps 0..CLKS_PER_BIT-1 and wraps; tick is high during the last count so
// the owner advances its bit position on the edge that wraps the counter.
// While run is low the counter is held at 0, so every new transfer starts on
// a clean bit boundary.
//
// Ports:
//   pclk     in   rising-edge clock
//   presetn  in   asynchronous active-low reset
//   run      in   enable; low clears the counter
//   tick     out  one-cycle pulse in the final cycle of each bit period
// ============================================================================
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic pclk,
    input  logic presetn,
    input  logic run,
    output logic tick
);

    localparam logic [15:0] LAST_COUNT = 16'(CLKS_PER_BIT - 1);

    logic [15:0] count;

    // Free-running bit timer, cleared whenever the transmitter is idle.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            count <= '0;
        end else if (!run) begin
            count <= '0;
        end else if (count == LAST_COUNT) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

    assign tick = run && (count == LAST_COUNT);

endmodule

// File: rtl/uart_tx_serializer.sv
// ============================================================================
// uart_tx_serializer
// ----------------------------------------------------------------------------
// Sends 1 to 4 bytes of a 32-bit word as back-to-back 8N1 UART frames, least
// significant byte first, each bit held CLKS_PER_BIT clocks.  A one-cycle dv
// strobe from the APB slave starts a transfer; dv is ignored while busy and
// in the first cycle after reset releases.
//
// Ports:
//   pclk     in   rising-edge clock
//   presetn  in   asynchronous active-low reset
//   dv       in   data-valid strobe, accepted only when idle
//   data_in  in   [31:0] word to send, captured with dv
//   nbytes   in   [1:0] byte-count code (00=1 .. 11=4), captured with dv
//   u_busy   out  high while a transfer is in progress
//   tx       out  serial line, idle high
//   done     out  one-cycle pulse after the last stop bit
// ============================================================================
module uart_tx_serializer
    import periplex_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        dv,
    input  logic [31:0] data_in,
    input  logic [1:0]  nbytes,
    output logic        u_busy,
    output logic        tx,
    output logic        done
);

    uart_state_t state;
    uart_state_t next_state;

    logic [31:0] shift_reg;
    logic [1:0]  nbytes_q;
    logic [2:0]  bit_idx;
    logic [1:0]  byte_idx;
    logic        armed;
    logic        accept;
    logic        tick;
    logic        run;
    logic        last_byte;

    assign run       = (state != IDLE);
    assign last_byte = (byte_idx == nbytes_q);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .pclk    (pclk),
        .presetn (presetn),
        .run     (run),
        .tick    (tick)
    );

    // State register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and line outputs.  tx and u_busy are decoded from the
    // current state so they change on the same edge that changes state, and
    // an asynchronous reset returns tx high without waiting for a clock.
    always_comb begin
        next_state = state;
        tx         = 1'b1;
        u_busy     = 1'b1;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                u_busy = 1'b0;
                if (dv && armed) begin
                    accept     = 1'b1;
                    next_state = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (tick) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                tx = shift_reg[0];
                if (tick && (bit_idx == 3'd7)) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    next_state = last_byte ? IDLE : START;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath.  The word is shifted right one bit per data bit, so after
    // eight shifts the next byte to send already sits in the low bits and
    // the following frame can start without any byte selection.  armed stays
    // low for the first clock after reset so a dv in that cycle is dropped.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            shift_reg <= '0;
            nbytes_q  <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            armed     <= 1'b0;
            done      <= 1'b0;
        end else begin
            armed <= 1'b1;
            done  <= 1'b0;
            if (accept) begin
                shift_reg <= data_in;
                nbytes_q  <= nbytes;
                bit_idx   <= '0;
                byte_idx  <= '0;
            end
            if ((state == DATA) && tick) begin
                shift_reg <= {1'b0, shift_reg[31:1]};
                bit_idx   <= bit_idx + 3'd1;
            end
            if ((state == STOP) && tick) begin
                if (last_byte) begin
                    done <= 1'b1;
                end else begin
                    byte_idx <= byte_idx + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// ============================================================================
// tb_uart_tx_serializer
// ----------------------------------------------------------------------------
// Self-checking bench for uart_tx_serializer with CLKS_PER_BIT = 4.  Each
// transfer is captured cycle by cycle starting with the first cycle after dv
// is accepted, then compared against an ideal 8N1 waveform built from the
// expected byte sequence, and the serial line is also decoded at mid-bit.
// ============================================================================
module tb_uart_tx_serializer;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;
    localparam int MAXC  = 256;

    logic        pclk;
    logic        presetn;
    logic        dv;
    logic [31:0] data_in;
    logic [1:0]  nbytes;
    logic        u_busy;
    logic        tx;
    logic        done;

    int tests_run;
    int tests_failed;

    logic tx_s   [MAXC];
    logic busy_s [MAXC];
    logic done_s [MAXC];
    int   cap_len;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic [1:0]  nb;
        logic [31:0] exp_bytes;
        int          exp_busy;
    } vec_t;

    uart_tx_serializer #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .dv      (dv),
        .data_in (data_in),
        .nbytes  (nbytes),
        .u_busy  (u_busy),
        .tx      (tx),
        .done    (done)
    );

    // Free-running clock, period 10.
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Scalar comparison with pass/fail bookkeeping.
    task automatic checkSignal(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Pulse dv with the given word and record tx/u_busy/done for ncyc cycles,
    // sampled 1 time unit after each rising edge.  Sample 0 is the first
    // cycle after the edge that accepts dv.  An optional second dv is fired
    // at capture cycle inj_cycle to show that a busy transmitter ignores it.
    task automatic applyStimulus(input logic [31:0] d, input logic [1:0] nb,
                                 input int ncyc, input int inj_cycle,
                                 input logic [31:0] inj_data);
        data_in = d;
        nbytes  = nb;
        dv      = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge pclk);
            #1;
            if (c == 0) begin
                dv      = 1'b0;
                data_in = '0;
                nbytes  = '0;
            end
            if (c == inj_cycle) begin
                dv      = 1'b1;
                data_in = inj_data;
                nbytes  = 2'b11;
            end else if (c == inj_cycle + 1) begin
                dv = 1'b0;
            end
            tx_s[c]   = tx;
            busy_s[c] = u_busy;
            done_s[c] = done;
        end
        cap_len = ncyc;
    endtask

    // Ideal line level at capture cycle c for a transfer of nb+1 bytes.
    function automatic logic expTx(input int c, input logic [31:0] bytes, input logic [1:0] nb);
        int total;
        int b;
        int pos;
        total = (int'(nb) + 1) * FRAME;
        if (c >= total) return 1'b1;
        b   = c / FRAME;
        pos = (c % FRAME) / CPB;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return bytes[b * 8 + pos - 1];
    endfunction

    // Compare the last capture against the ideal waveform and byte list.
    task automatic checkOutput(input string name, input logic [31:0] bytes,
                               input logic [1:0] nb, input int exp_busy);
        int   total;
        int   bad_tx;
        int   bad_busy;
        int   bad_done;
        int   busy_cnt;
        int   done_cnt;
        logic [7:0] got;
        total    = (int'(nb) + 1) * FRAME;
        bad_tx   = -1;
        bad_busy = -1;
        bad_done = -1;
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < cap_len; c++) begin
            if (busy_s[c]) busy_cnt++;
            if (done_s[c]) done_cnt++;
            if (bad_tx < 0 && tx_s[c] !== expTx(c, bytes, nb)) bad_tx = c;
            if (bad_busy < 0 && busy_s[c] !== (c < total)) bad_busy = c;
            if (bad_done < 0 && done_s[c] !== (c == total)) bad_done = c;
        end
        checkSignal({name, " tx first bad cycle"}, bad_tx, -1);
        checkSignal({name, " u_busy first bad cycle"}, bad_busy, -1);
        checkSignal({name, " done first bad cycle"}, bad_done, -1);
        checkSignal({name, " u_busy cycles"}, busy_cnt, exp_busy);
        checkSignal({name, " done pulses"}, done_cnt, 1);
        for (int b = 0; b <= int'(nb); b++) begin
            for (int i = 0; i < 8; i++) begin
                got[i] = tx_s[b * FRAME + (i + 1) * CPB + CPB / 2];
            end
            checkSignal($sformatf("%s byte%0d", name, b), int'(got), int'(bytes[b * 8 +: 8]));
        end
    endtask

    initial begin
        vec_t vecs[4];
        int   low_cnt;
        int   busy_cnt;
        int   done_cnt;

        tests_run    = 0;
        tests_failed = 0;
        cap_len      = 0;

        vecs[0] = '{"single_a5",   32'h0000_00A5, 2'b00, 32'h0000_00A5, 40};
        vecs[1] = '{"word_4bytes", 32'h1234_5678, 2'b11, 32'h1234_5678, 160};
        vecs[2] = '{"two_bytes",   32'hDEAD_BEEF, 2'b01, 32'h0000_BEEF, 80};
        vecs[3] = '{"three_bytes", 32'h0081_FF00, 2'b10, 32'h0081_FF00, 120};

        // Reset state, checked while reset is held and after release.
        presetn = 1'b0;
        dv      = 1'b0;
        data_in = '0;
        nbytes  = '0;
        #1;
        checkSignal("reset tx", int'(tx), 1);
        checkSignal("reset u_busy", int'(u_busy), 0);
        checkSignal("reset done", int'(done), 0);
        repeat (3) @(posedge pclk);
        #1;
        presetn = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        checkSignal("post-reset tx", int'(tx), 1);
        checkSignal("post-reset u_busy", int'(u_busy), 0);

        // Table-driven transfers, each followed by a short idle tail.
        foreach (vecs[k]) begin
            applyStimulus(vecs[k].data, vecs[k].nb, vecs[k].exp_busy + 4, -1, '0);
            checkOutput(vecs[k].name, vecs[k].exp_bytes, vecs[k].nb, vecs[k].exp_busy);
        end

        // dv with 0xFF while byte 0 is in flight must not disturb the frame.
        applyStimulus(32'h0000_00A5, 2'b00, 48, 10, 32'h0000_00FF);
        checkOutput("dv_while_busy", 32'h0000_00A5, 2'b00, 40);

        // Back-to-back: capture ends on the cycle after done, and the next
        // dv is raised in that very cycle.
        applyStimulus(32'h0000_005A, 2'b00, 42, -1, '0);
        checkOutput("b2b_first", 32'h0000_005A, 2'b00, 40);
        applyStimulus(32'h0000_003C, 2'b00, 43, -1, '0);
        checkSignal("b2b immediate start bit", int'(tx_s[0]), 0);
        checkOutput("b2b_second", 32'h0000_003C, 2'b00, 40);

        // Mid-transfer reset during data bit 3 (capture cycles 16..19).
        applyStimulus(32'h0000_00A5, 2'b00, 18, -1, '0);
        checkSignal("pre-reset data bit3", int'(tx_s[17]), 0);
        checkSignal("pre-reset busy", int'(busy_s[17]), 1);
        presetn = 1'b0;
        #1;
        checkSignal("abort tx", int'(tx), 1);
        checkSignal("abort u_busy", int'(u_busy), 0);
        checkSignal("abort done", int'(done), 0);
        repeat (2) @(posedge pclk);
        #1;
        // Release reset with dv already high: the first edge must drop it.
        presetn = 1'b1;
        dv      = 1'b1;
        data_in = 32'h0000_00A5;
        nbytes  = 2'b00;
        low_cnt  = 0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge pclk);
            #1;
            dv = 1'b0;
            if (tx !== 1'b1) low_cnt++;
            if (u_busy !== 1'b0) busy_cnt++;
            if (done !== 1'b0) done_cnt++;
        end
        checkSignal("after abort tx low cycles", low_cnt, 0);
        checkSignal("after abort busy cycles", busy_cnt, 0);
        checkSignal("after abort done pulses", done_cnt, 0);

        // A fresh transfer works normally after the aborted one.
        applyStimulus(32'h0000_00C3, 2'b00, 44, -1, '0);
        checkOutput("recover_c3", 32'h0000_00C3, 2'b00, 40);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
